// File: rtl/s_cpu_irq_pkg.sv
// Shared types and constants for the S_CPU_IRQ interrupt controller.
// Holds the handshake state encoding, register map and default sizing.
package s_cpu_irq_pkg;

  localparam int DEF_NUM_IRQ = 4;
  localparam int DEF_ID_W    = 2;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/s_cpu_irq_ctrl_if.sv
// CPU-facing bundle: config register port plus the req/ack/EOI interrupt handshake.
// master = CPU side, slave = controller side.
interface s_cpu_irq_ctrl_if
  import s_cpu_irq_pkg::*;
#(
  parameter int NUM_IRQ = DEF_NUM_IRQ,
  parameter int ID_W    = DEF_ID_W
) ();

  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_eoi;
  logic               irq_active;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_eoi,
    input  cfg_rdata, irq_req, irq_id, irq_active
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_eoi,
    output cfg_rdata, irq_req, irq_id, irq_active
  );

endinterface

// File: rtl/s_cpu_irq_arb.sv
// Purpose: picks one line from the eligible vector, searching upward from rr_ptr+1 (mod NUM_IRQ).
// Latency: purely combinational. Backpressure: none; rr_ptr=NUM_IRQ-1 gives fixed lowest-index priority.
module s_cpu_irq_arb #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_IRQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    win_id,
  output logic               win_vld
);

  int idx;

  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx = (int'(rr_ptr) + 1 + k) % NUM_IRQ;
      if (!win_vld && eligible[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/s_cpu_irq_ctrl.sv
// Purpose: sync/pend/arbitrate fabric IRQ lines into a req/ack/EOI CPU handshake; S_CPU_IRQ_RR_EN selects round-robin.
// Latency: IRQ sampled at edge 1 -> pending at edge 3 -> irq_req after edge 4 (level and edge mode).
// Backpressure: one interrupt in flight; new requests wait until EOI, pending state holds meanwhile.
module s_cpu_irq_ctrl
  import s_cpu_irq_pkg::*;
#(
  parameter int NUM_IRQ = DEF_NUM_IRQ,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic               UserCLK,
  input  logic               RESETn,
  input  logic [NUM_IRQ-1:0] IRQ,
  s_cpu_irq_ctrl_if.slave    bus
);

  logic [NUM_IRQ-1:0] s1, s2, s3;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] enable_q, mode_q, pend_q, pend_d;
  logic [NUM_IRQ-1:0] w1c, clr, eligible, id_mask;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [ID_W-1:0]    rr_ptr;
  logic               claim;

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= IRQ;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      enable_q <= '0;
      mode_q   <= '0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr == ADDR_ENABLE) enable_q <= bus.cfg_wdata;
      if (bus.cfg_addr == ADDR_MODE)   mode_q   <= bus.cfg_wdata;
    end
  end

  assign claim   = (state_q == REQ) && bus.irq_ack;
  assign id_mask = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_q;
  assign w1c     = (bus.cfg_we && bus.cfg_addr == ADDR_PENDING) ? bus.cfg_wdata : '0;
  assign clr     = w1c | (claim ? id_mask : '0);

  // Level bits simply track the synchronised line, so clears never reach them.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_d[i] = mode_q[i] ? ((pend_q[i] & ~clr[i]) | rise[i]) : s2[i];
    end
  end

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign eligible = pend_q & enable_q;

`ifdef S_CPU_IRQ_RR_EN
  logic [ID_W-1:0] rr_ptr_q;

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn)    rr_ptr_q <= ID_W'(NUM_IRQ - 1);
    else if (claim) rr_ptr_q <= id_q;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = ID_W'(NUM_IRQ - 1);
`endif

  s_cpu_irq_arb #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .win_id   (win_id),
    .win_vld  (win_vld)
  );

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Ack beats withdrawal: a claimed line is serviced even if it dropped this cycle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.irq_ack)                  state_d = ACTIVE;
        else if (~|(eligible & id_mask))  state_d = IDLE;
      end
      ACTIVE: begin
        if (bus.irq_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.irq_req    = (state_q == REQ);
  assign bus.irq_active = (state_q == ACTIVE);
  assign bus.irq_id     = id_q;

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      ADDR_ENABLE:  bus.cfg_rdata = enable_q;
      ADDR_MODE:    bus.cfg_rdata = mode_q;
      ADDR_PENDING: bus.cfg_rdata = pend_q;
      ADDR_STATUS:  bus.cfg_rdata = s2;
      default:      bus.cfg_rdata = '0;
    endcase
  end

endmodule

// File: doc/s_cpu_irq_ctrl.md
Name: s_cpu_irq_ctrl

Overview:
- Interrupt controller between the S_CPU_IRQ tile's fabric-routed IRQ lines and the CPU core's interrupt port.
- Synchronises the raw lines and applies per-line enable and edge/level mode.
- Holds pending state, arbitrates between pending lines and presents one interrupt ID at a time to the CPU.
- Uses a req/ack/EOI handshake with the CPU.
- Configured through a small register write/read port driven by the CPU.

Parameters:
- NUM_IRQ, 4, number of IRQ lines from the switch matrix (2..8).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= NUM_IRQ.

Ports:
- UserCLK  input  1  fabric user clock; all state on rising edge.
- RESETn  input  1  asynchronous active-low reset.
- IRQ  input  NUM_IRQ  raw interrupt lines from the switch matrix, asynchronous to UserCLK.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select: 0 ENABLE, 1 MODE (1=edge, 0=level), 2 PENDING (write-1-to-clear), 3 STATUS (read-only).
- cfg_wdata  input  NUM_IRQ  write data.
- cfg_rdata  output  NUM_IRQ  combinational read of the register at cfg_addr.
  - STATUS = synchronised IRQ levels.
- irq_req  output  1  interrupt request to CPU.
- irq_id  output  ID_W  index of the requested or active line.
- irq_ack  input  1  CPU claims the current request.
- irq_eoi  input  1  CPU end-of-interrupt for the active line.
- irq_active  output  1  a claimed interrupt is in service.

Behaviour:
- Reset (asynchronous, RESETn=0):
  - ENABLE=0, MODE=0, all pending=0, all sync flops=0.
  - State=IDLE; irq_req=0, irq_id=0, irq_active=0.
- Synchronisation:
  - Per line: 2-flop synchroniser s1→s2, plus delay flop s3.
  - rise[i] = s2 & ~s3.
- Pending register, updated every cycle:
  - Level mode: pend[i] <= s2[i].
  - Edge mode: pend[i] <= (pend[i] & ~clr[i]) | rise[i].
  - clr sources: PENDING write-1 bits, or claim of that ID.
  - Set wins over simultaneous clear.
  - Writes to PENDING have no effect on level-mode bits.
- Eligible = pend & ENABLE. Winner = lowest eligible index (fixed priority).
- Latency: IRQ[i] high sampled at edge 1 → pend at edge 3 → irq_req=1 after edge 4, in both modes.
- FSM states:
  - IDLE: irq_req=0, irq_active=0.
    - If any line is eligible: latch winner into irq_id, go to REQ.
  - REQ: irq_req=1, irq_id held stable.
    - irq_ack=1: go to ACTIVE; clear pend[irq_id] if it is edge mode.
    - Else, if the latched line is no longer eligible (disabled, level dropped, or W1C): withdraw, go to IDLE. irq_req falls next cycle.
    - irq_ack has priority over withdrawal in the same cycle.
  - ACTIVE: irq_req=0, irq_active=1, irq_id held.
    - irq_eoi=1: go to IDLE.
    - No new request is issued while ACTIVE (no nesting).
- irq_ack outside REQ and irq_eoi outside ACTIVE are ignored.
- Config writes take effect on the next edge and are legal in any state.
- Back-to-back: after EOI, IDLE re-arbitrates the next cycle. irq_req reasserts 2 cycles after the EOI edge if another line is pending.
- Reset mid-handshake returns to IDLE immediately and drops all pending; the CPU must treat it as a spurious abort.

Optional Feature:
- Macro S_CPU_IRQ_RR_EN.
- Defined: round-robin arbitration.
  - A last-granted pointer is updated on each claim (irq_ack in REQ).
  - Search starts at pointer+1 modulo NUM_IRQ.
  - Pointer resets to NUM_IRQ-1, so the first grant favours line 0.
- Undefined: fixed priority, lowest index wins; no pointer flops.

Decomposition:
- Package s_cpu_irq_pkg holds:
  - state enum (IDLE, REQ, ACTIVE);
  - register address constants (ADDR_ENABLE=0, ADDR_MODE=1, ADDR_PENDING=2, ADDR_STATUS=3);
  - default NUM_IRQ/ID_W.
- Sub-module s_cpu_irq_arb: combinational eligible-vector → winner/valid encoder, with optional RR pointer input.

Test Plan:
- ENABLE=0xF, MODE=0, raise IRQ[2] at cycle 0 → irq_req=1, irq_id=2 at cycle 4; ack → irq_active=1; eoi → IDLE; IRQ[2] still high → irq_req again 2 cycles later.
- MODE=0xF, ENABLE=0xF, 1-cycle pulses on IRQ[1] and IRQ[3] together → id=1 first; after ack+eoi, id=3; pend reads 0 after both claims.
- Edge mode, ENABLE=0x1, pulse IRQ[0], then write ENABLE=0 while in REQ → irq_req drops next cycle; re-enable → request reappears with id=0 (pend still set).
- Edge mode, W1C PENDING=0x1 in the same cycle as a new rise on IRQ[0] → pend[0] stays 1.
- RESETn low while ACTIVE → irq_active=0, irq_req=0, cfg_rdata for ENABLE=0 immediately.
- With S_CPU_IRQ_RR_EN: lines 0 and 1 held high in level mode, repeated ack/eoi → ids alternate 0,1,0,1. Without the macro → 0,0,0.
